// File: rtl/param_memory_pkg.sv
// Shared types, default geometry and helpers for param_memory.
// Contents:
//   state_t         - controller state (CLEAR while initialising, IDLE when serving)
//   DEF_*           - default width/depth constants
//   addr_in_range() - 1 when a request address selects a real word
package mem_pkg;

  typedef enum logic {CLEAR, IDLE} state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DEPTH      = 32;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/param_memory_array.sv
// mem_array_sp: plain single-port storage array, synchronous write,
// registered read, no reset.
// Ports:
//   clk   - rising-edge clock
//   we    - write enable, wdata stored at addr
//   re    - read enable, rdata loads mem[addr]; otherwise rdata holds
//   addr  - word address (AW bits)
//   wdata - write data
//   rdata - registered read data
module mem_array_sp #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 32,
  localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/param_memory.sv
// param_memory: parametrised single-port RAM behind a valid/ready request
// channel and a valid/ready response channel, one request in flight.
// After reset every word is overwritten with CLEAR_VALUE (DEPTH cycles,
// busy=1); addresses >= DEPTH answer with rsp_error=1 and rsp_rdata=0.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   req_valid/req_ready        - request handshake
//   req_write/addr/wdata       - request payload (1 = write)
//   rsp_valid/rsp_ready        - response handshake
//   rsp_rdata/rsp_error        - read data or echoed write data, range error
//   busy                       - clear sequence running
// Build option: MEM_OUT_REG_EN adds an output pipeline stage (2-cycle latency).
module param_memory
  import mem_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int                    DEPTH       = DEF_DEPTH,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t                state, state_nxt;
  logic [AW-1:0]         clr_ptr;
  logic                  accept, in_range;
  logic                  arr_we, arr_re;
  logic [AW-1:0]         arr_addr;
  logic [DATA_WIDTH-1:0] arr_wdata, arr_rdata;
  logic [DATA_WIDTH-1:0] rsp_data;

  assign in_range = addr_in_range(32'(req_addr), DEPTH);
  assign busy     = (state == CLEAR);
  assign accept   = req_valid && req_ready;

  // The clear sequence and accepted requests share the single array port;
  // they never overlap because req_ready is low during CLEAR.
  always_comb begin
    state_nxt = state;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_addr  = AW'(req_addr);
    arr_wdata = req_wdata;
    case (state)
      CLEAR: begin
        arr_we    = 1'b1;
        arr_addr  = clr_ptr;
        arr_wdata = CLEAR_VALUE;
        if (clr_ptr == AW'(DEPTH - 1)) state_nxt = IDLE;
      end
      IDLE: begin
        if (accept && in_range) begin
          arr_we = req_write;
          arr_re = !req_write;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_ptr <= clr_ptr + AW'(1);
    end
  end

  mem_array_sp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

`ifdef MEM_OUT_REG_EN
  // One-deep stage between acceptance and the response register; the array
  // output is captured into rsp_data when the stage drains.
  logic                  pipe_valid, pipe_rd, pipe_err;
  logic [DATA_WIDTH-1:0] pipe_data;
  logic                  pipe_drain;

  assign req_ready  = (state == IDLE) && !pipe_valid && (!rsp_valid || rsp_ready);
  assign pipe_drain = pipe_valid && (!rsp_valid || rsp_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= 1'b0;
      pipe_rd    <= 1'b0;
      pipe_err   <= 1'b0;
      pipe_data  <= '0;
    end else if (accept) begin
      pipe_valid <= 1'b1;
      pipe_rd    <= in_range && !req_write;
      pipe_err   <= !in_range;
      pipe_data  <= (in_range && req_write) ? req_wdata : '0;
    end else if (pipe_drain) begin
      pipe_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_data  <= '0;
    end else if (pipe_drain) begin
      rsp_valid <= 1'b1;
      rsp_error <= pipe_err;
      rsp_data  <= pipe_rd ? arr_rdata : pipe_data;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_rdata = rsp_data;
`else
  // Read data comes straight from the array's registered output; it holds
  // because the array only reads on an accepted read.
  logic rsp_rd;

  assign req_ready = (state == IDLE) && (!rsp_valid || rsp_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rd    <= 1'b0;
      rsp_data  <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_error <= !in_range;
      rsp_rd    <= in_range && !req_write;
      rsp_data  <= (in_range && req_write) ? req_wdata : '0;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign rsp_rdata = rsp_rd ? arr_rdata : rsp_data;
`endif

endmodule

// File: tb/tb_param_memory.sv
// Directed bench for param_memory: a default instance (DEPTH=32) and a
// DEPTH=17 instance for out-of-range addresses. Honours MEM_OUT_REG_EN.
module tb_param_memory;

`ifdef MEM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0, v17 = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
  logic [4:0] req_addr = '0;
  logic [7:0] req_wdata = '0;

  logic       req_ready, rsp_valid, rsp_error, busy;
  logic [7:0] rsp_rdata;
  logic       ready17, valid17, error17, busy17;
  logic [7:0] rdata17;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  param_memory dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .busy(busy)
  );

  param_memory #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(17), .CLEAR_VALUE(8'h00)) dut17 (
    .clk(clk), .rst_n(rst_n), .req_valid(v17), .req_ready(ready17),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(valid17), .rsp_ready(rsp_ready), .rsp_rdata(rdata17),
    .rsp_error(error17), .busy(busy17)
  );

  typedef struct {
    logic       w;
    logic [4:0] a;
    logic [7:0] d;
    logic [7:0] exp;
    logic       err;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input bit s);
    return s ? ready17 : req_ready;
  endfunction

  function automatic logic vld(input bit s);
    return s ? valid17 : rsp_valid;
  endfunction

  // Issue one request on instance s, wait for acceptance and then for the
  // response; lat counts edges from acceptance to rsp_valid.
  task automatic do_req(input bit s, input logic w, input logic [4:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic er, output int lat);
    int n;
    req_write = w; req_addr = a; req_wdata = d;
    if (s) v17 = 1'b1; else req_valid = 1'b1;
    n = 0;
    while (!rdy(s) && n < 100) begin @(posedge clk); #1; n++; end
    if (!rdy(s)) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; v17 = 1'b0;
`ifdef MEM_OUT_REG_EN
    chk("ready_while_pipe_busy", 32'(rdy(s)), 32'd0);
`endif
    lat = 1;
    while (!vld(s) && lat < 10) begin @(posedge clk); #1; lat++; end
    rd = s ? rdata17 : rsp_rdata;
    er = s ? error17 : rsp_error;
  endtask

  task automatic wait_clear(input string nm);
    int  cyc;
    bit  bad;
    cyc = 0; bad = 0;
    while (busy && cyc < 100) begin
      if (req_ready) bad = 1;
      @(posedge clk); #1; cyc++;
    end
    chk({nm, "_cycles"}, 32'(cyc), 32'd32);
    chk({nm, "_ready_during"}, 32'(bad), 32'd0);
    chk({nm, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic       er;
    int         lat;

    tbl[0]  = '{1'b1, 5'd3,  8'h42, 8'h42, 1'b0};
    tbl[1]  = '{1'b0, 5'd3,  8'h00, 8'h42, 1'b0};
    tbl[2]  = '{1'b1, 5'd31, 8'h5A, 8'h5A, 1'b0};
    tbl[3]  = '{1'b0, 5'd31, 8'h00, 8'h5A, 1'b0};
    tbl[4]  = '{1'b1, 5'd5,  8'h3C, 8'h3C, 1'b0};
    tbl[5]  = '{1'b0, 5'd5,  8'h00, 8'h3C, 1'b0};
    tbl[6]  = '{1'b1, 5'd2,  8'h11, 8'h11, 1'b0};
    tbl[7]  = '{1'b0, 5'd2,  8'h00, 8'h11, 1'b0};
    tbl[8]  = '{1'b1, 5'd0,  8'h01, 8'h01, 1'b0};
    tbl[9]  = '{1'b0, 5'd0,  8'h00, 8'h01, 1'b0};
    tbl[10] = '{1'b0, 5'd30, 8'h00, 8'h00, 1'b0};
    tbl[11] = '{1'b1, 5'd16, 8'h77, 8'h77, 1'b0};
    tbl[12] = '{1'b0, 5'd16, 8'h00, 8'h77, 1'b0};

    // Reset state
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",      32'(busy),      32'd1);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    rst_n = 1'b1;
    wait_clear("clear");
    chk("clear17_done", 32'(busy17), 32'd0);

    // Whole array reads back as CLEAR_VALUE
    for (int i = 0; i < 32; i++) begin
      do_req(1'b0, 1'b0, 5'(i), 8'h00, rd, er, lat);
      chk($sformatf("clear_rd%0d", i), 32'({lat[3:0], er, rd}), 32'({4'(LAT), 1'b0, 8'h00}));
    end

    // Table vectors
    for (int i = 0; i < 13; i++) begin
      do_req(1'b0, tbl[i].w, tbl[i].a, tbl[i].d, rd, er, lat);
      chk($sformatf("vec%0d", i), 32'({lat[3:0], er, rd}),
          32'({4'(LAT), tbl[i].err, tbl[i].exp}));
    end

    // Write then read the same word on consecutive edges
    @(posedge clk); #1;
`ifndef MEM_OUT_REG_EN
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd3; req_wdata = 8'hA5;
    @(posedge clk); #1;
    chk("b2b_wr_rsp", 32'({rsp_valid, rsp_error, rsp_rdata}), 32'({1'b1, 1'b0, 8'hA5}));
    req_write = 1'b0;
    @(posedge clk); #1;
    chk("b2b_rd_rsp", 32'({rsp_valid, rsp_error, rsp_rdata}), 32'({1'b1, 1'b0, 8'hA5}));
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle", 32'(rsp_valid), 32'd0);
`else
    do_req(1'b0, 1'b1, 5'd3, 8'hA5, rd, er, lat);
    chk("b2b_wr_rsp", 32'({lat[3:0], er, rd}), 32'({4'd2, 1'b0, 8'hA5}));
    do_req(1'b0, 1'b0, 5'd3, 8'h00, rd, er, lat);
    chk("b2b_rd_rsp", 32'({lat[3:0], er, rd}), 32'({4'd2, 1'b0, 8'hA5}));
`endif

    // Out-of-range on the DEPTH=17 instance
    do_req(1'b1, 1'b1, 5'd16, 8'h99, rd, er, lat);
    chk("d17_wr16", 32'({er, rd}), 32'({1'b0, 8'h99}));
    do_req(1'b1, 1'b0, 5'd20, 8'h00, rd, er, lat);
    chk("d17_rd20_err", 32'({lat[3:0], er, rd}), 32'({4'(LAT), 1'b1, 8'h00}));
    do_req(1'b1, 1'b1, 5'd17, 8'hEE, rd, er, lat);
    chk("d17_wr17_err", 32'({er, rd}), 32'({1'b1, 8'h00}));
    do_req(1'b1, 1'b0, 5'd16, 8'h00, rd, er, lat);
    chk("d17_rd16", 32'({er, rd}), 32'({1'b0, 8'h99}));

    // Response backpressure
    rsp_ready = 1'b0;
    do_req(1'b0, 1'b0, 5'd5, 8'h00, rd, er, lat);
    chk("bp_first", 32'({er, rd}), 32'({1'b0, 8'h3C}));
    req_addr = 5'd9; req_wdata = 8'hCC; req_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", i), 32'({rsp_valid, req_ready, rsp_error, rsp_rdata}),
          32'({1'b1, 1'b0, 1'b0, 8'h3C}));
    end
    rsp_ready = 1'b1; #1;
    chk("bp_ready_same_cycle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_consumed", 32'(rsp_valid), 32'd0);

    // Reset in the middle of a held response
    do_req(1'b0, 1'b1, 5'd7, 8'hFF, rd, er, lat);
    chk("mid_wr7", 32'({er, rd}), 32'({1'b0, 8'hFF}));
    rsp_ready = 1'b0;
    do_req(1'b0, 1'b0, 5'd7, 8'h00, rd, er, lat);
    chk("mid_rd7", 32'({rsp_valid, rd}), 32'({1'b1, 8'hFF}));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_drop", 32'({rsp_valid, busy, req_ready}), 32'({1'b0, 1'b1, 1'b0}));
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = 1'b1;
    wait_clear("reclear");
    do_req(1'b0, 1'b0, 5'd7, 8'h00, rd, er, lat);
    chk("reclear_rd7", 32'({er, rd}), 32'({1'b0, 8'h00}));
    do_req(1'b0, 1'b0, 5'd3, 8'h00, rd, er, lat);
    chk("reclear_rd3", 32'({er, rd}), 32'({1'b0, 8'h00}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_memory.md
Name: param_memory

Overview:
- Parametrised single-port synchronous RAM with a valid/ready request channel and a valid/ready response channel.
- Generalises the existing 8-bit scratch memory: configurable width and depth, power-up clear sequence, out-of-range detection, and response backpressure.
- Sits between the FPGA control logic and any datapath needing small local storage; one request in flight.

Parameters:
- DATA_WIDTH, 8, bits per word.
- ADDR_WIDTH, 5, request address width.
- DEPTH, 32, number of words; legal range 1..2**ADDR_WIDTH.
- CLEAR_VALUE, 0, word value written to every location during the clear sequence (DATA_WIDTH bits).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronised to clk by the integrator.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_WIDTH  read data, or echoed write data.
- rsp_error  out  1  the request address was >= DEPTH.
- busy  out  1  clear sequence in progress.

Behaviour:
- Reset values (async, on rst_n low):
  - state=CLEAR, clear pointer=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=1.
  - Array contents are not reset directly; the clear sequence overwrites them.
- State CLEAR:
  - Writes CLEAR_VALUE to the word at the clear pointer each cycle, then increments the pointer.
  - After writing word DEPTH-1, moves to IDLE on the next edge. Total duration is DEPTH cycles after reset release.
  - req_ready=0 throughout; requests are ignored.
- State IDLE:
  - req_ready = !rsp_valid || rsp_ready. A single response register allows full throughput when rsp_ready is held high.
  - A request is accepted on a clk edge when req_valid && req_ready.
- Accepted write, addr < DEPTH: mem[addr] <= req_wdata; response next cycle with rsp_rdata=req_wdata, rsp_error=0.
- Accepted read, addr < DEPTH: response next cycle with rsp_rdata=mem[addr], rsp_error=0. Read latency is 1 cycle from acceptance.
- Accepted request, addr >= DEPTH: no array access; response next cycle with rsp_rdata=0, rsp_error=1.
- Response hold: rsp_valid stays high and rsp_rdata/rsp_error stay stable until rsp_ready=1.
  - On the accepting edge, rsp_valid drops unless a new request is accepted on the same edge, in which case the response register reloads.
- Read after write, back to back: the read returns the newly written data. Writes commit on the accepting edge.
- Reset mid-operation: any pending response is dropped, the clear sequence restarts from address 0, and all contents become CLEAR_VALUE.
- Input sampling: req_* inputs are sampled only on acceptance edges; changes at other times have no effect.

Optional Feature:
- MEM_OUT_REG_EN defined:
  - Adds a pipeline register after the array read. Read/write/error latency becomes 2 cycles.
  - The internal pipeline holds at most one in-flight request.
  - req_ready = !pipe_valid && (!rsp_valid || rsp_ready).
  - Reset clears pipe_valid.
- MEM_OUT_REG_EN undefined: 1-cycle latency as above, no extra register.

Decomposition:
- Package mem_pkg holds:
  - state enum {CLEAR, IDLE}.
  - Default width/depth constants.
  - Helper function addr_in_range(addr, depth).
- One sub-module, mem_array_sp: a plain single-port synchronous write, registered read array with no reset, parametrised by DATA_WIDTH/DEPTH.
- The top level owns the FSM, the clear counter and the handshake.

Test Plan:
- Release rst_n with DATA_WIDTH=8, DEPTH=32, CLEAR_VALUE=8'h00 -> busy=1 and req_ready=0 for exactly 32 cycles, then req_ready=1; reading addr 0..31 returns 8'h00 with rsp_error=0.
- Write 8'hA5 to addr 3, then read addr 3 on the next cycle with rsp_ready=1 -> write response rsp_rdata=8'hA5, then read response 8'hA5; one response per cycle, no bubbles.
- DEPTH=17, ADDR_WIDTH=5, read addr 20 -> rsp_error=1, rsp_rdata=0; a following read of addr 16 returns its stored data with rsp_error=0.
- Hold rsp_ready=0 after a read of addr 5 (data 8'h3C) -> rsp_valid and 8'h3C held for 4 cycles, req_ready=0; raise rsp_ready -> response consumed and req_ready=1 the same cycle.
- Write 8'hFF to addr 7, assert rst_n low mid-stream with rsp_valid=1 -> rsp_valid=0 immediately (async); after the 32-cycle clear, a read of addr 7 returns 8'h00.
- MEM_OUT_REG_EN defined: read addr 2 holding 8'h11 -> rsp_valid asserts 2 cycles after acceptance; req_ready low while the pipeline is occupied.
